// File: rtl/elevator_scheduler.sv
// Single-car elevator scheduler for an 8-floor shaft: collective up/down sweep with
// fixed per-floor travel time and fixed door dwell, driven by a pending-request buffer.
module elevator_scheduler #(
    parameter int unsigned TRAVEL_CYCLES = 100,
    parameter int unsigned DOOR_CYCLES   = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] upcall,
    input  logic [7:0] downcall,
    input  logic [7:0] floor_btn,
    output logic [2:0] floor,
    output logic [3:0] status,
    output logic       dir,
    output logic       arrive,
    output logic       door_open
);

    localparam int unsigned FLOOR_W = 3;
    localparam int unsigned NFLOORS = 8;
    localparam int unsigned CNT_W   = 16;

    localparam logic [CNT_W-1:0] TRAVEL_LOAD = CNT_W'(TRAVEL_CYCLES - 1);
    localparam logic [CNT_W-1:0] DOOR_LOAD   = CNT_W'(DOOR_CYCLES - 1);

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_MOVE_UP   = 4'd1,
        ST_MOVE_DOWN = 4'd2,
        ST_DOOR_OPEN = 4'd7
    } state_e;

    state_e               state_q, state_d;
    logic [FLOOR_W-1:0]   floor_q, floor_d;
    logic                 dir_q, dir_d;
    logic                 arrive_q, arrive_d;
    logic                 door_open_q, door_open_d;
    logic [CNT_W-1:0]     travel_cnt_q, travel_cnt_d;
    logic [CNT_W-1:0]     door_cnt_q, door_cnt_d;

    logic [NFLOORS-1:0]   req;
    logic [FLOOR_W-1:0]   nf_up, nf_dn;
    logic                 above, below, here;
    logic                 stop_up, stop_dn, beyond_up, beyond_dn;

    // Floors strictly above / strictly below f; shifting past bit 7 leaves an empty mask at the top floor.
    function automatic logic [NFLOORS-1:0] mask_above(input logic [FLOOR_W-1:0] f);
        return ~((8'd2 << f) - 8'd1);
    endfunction

    function automatic logic [NFLOORS-1:0] mask_below(input logic [FLOOR_W-1:0] f);
        return (8'd1 << f) - 8'd1;
    endfunction

    assign req   = upcall | downcall | floor_btn;
    assign above = |(req & mask_above(floor_q));
    assign below = |(req & mask_below(floor_q));
    assign here  = req[floor_q];

    assign nf_up = floor_q + FLOOR_W'(1);
    assign nf_dn = floor_q - FLOOR_W'(1);

    // A down-call is served on the way up only when nothing lies beyond it, and vice versa.
    assign beyond_up = |(req & mask_above(nf_up));
    assign beyond_dn = |(req & mask_below(nf_dn));
    assign stop_up   = floor_btn[nf_up] | upcall[nf_up]   | (downcall[nf_up] & ~beyond_up);
    assign stop_dn   = floor_btn[nf_dn] | downcall[nf_dn] | (upcall[nf_dn]   & ~beyond_dn);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            floor_q      <= '0;
            dir_q        <= 1'b1;
            arrive_q     <= 1'b0;
            door_open_q  <= 1'b0;
            travel_cnt_q <= '0;
            door_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            floor_q      <= floor_d;
            dir_q        <= dir_d;
            arrive_q     <= arrive_d;
            door_open_q  <= door_open_d;
            travel_cnt_q <= travel_cnt_d;
            door_cnt_q   <= door_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        floor_d      = floor_q;
        dir_d        = dir_q;
        arrive_d     = 1'b0;
        travel_cnt_d = travel_cnt_q;
        door_cnt_d   = door_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (here) begin
                    state_d    = ST_DOOR_OPEN;
                    door_cnt_d = DOOR_LOAD;
                end else if (above && below && !dir_q) begin
                    state_d      = ST_MOVE_DOWN;
                    travel_cnt_d = TRAVEL_LOAD;
                end else if (above) begin
                    state_d      = ST_MOVE_UP;
                    dir_d        = 1'b1;
                    travel_cnt_d = TRAVEL_LOAD;
                end else if (below) begin
                    state_d      = ST_MOVE_DOWN;
                    dir_d        = 1'b0;
                    travel_cnt_d = TRAVEL_LOAD;
                end
            end

            ST_MOVE_UP: begin
                if (travel_cnt_q != '0) begin
                    travel_cnt_d = travel_cnt_q - CNT_W'(1);
                end else begin
                    floor_d  = nf_up;
                    arrive_d = 1'b1;
                    if (stop_up) begin
                        state_d    = ST_DOOR_OPEN;
                        door_cnt_d = DOOR_LOAD;
                    end else if (beyond_up) begin
                        travel_cnt_d = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_MOVE_DOWN: begin
                if (travel_cnt_q != '0) begin
                    travel_cnt_d = travel_cnt_q - CNT_W'(1);
                end else begin
                    floor_d  = nf_dn;
                    arrive_d = 1'b1;
                    if (stop_dn) begin
                        state_d    = ST_DOOR_OPEN;
                        door_cnt_d = DOOR_LOAD;
                    end else if (beyond_dn) begin
                        travel_cnt_d = TRAVEL_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end

            ST_DOOR_OPEN: begin
                if (door_cnt_q != '0) begin
                    door_cnt_d = door_cnt_q - CNT_W'(1);
                end else if (dir_q && above) begin
                    state_d      = ST_MOVE_UP;
                    travel_cnt_d = TRAVEL_LOAD;
                end else if (below) begin
                    state_d      = ST_MOVE_DOWN;
                    dir_d        = 1'b0;
                    travel_cnt_d = TRAVEL_LOAD;
                end else if (above) begin
                    state_d      = ST_MOVE_UP;
                    dir_d        = 1'b1;
                    travel_cnt_d = TRAVEL_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        door_open_d = (state_d == ST_DOOR_OPEN);
    end

    assign floor     = floor_q;
    assign status    = state_q;
    assign dir       = dir_q;
    assign arrive    = arrive_q;
    assign door_open = door_open_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Bench for elevator_scheduler: directed scenarios plus randomized call traffic, checked
// every cycle against an event-level car model that counts elapsed cycles per segment.
module tb_elevator_scheduler;

    localparam int TRAVEL = 4;
    localparam int DOOR   = 3;

    logic       clk;
    logic       rst = 1'b1;
    logic [7:0] upcall, downcall, floor_btn;
    logic [2:0] floor;
    logic [3:0] status;
    logic       dir, arrive, door_open;

    int    n_checks = 0;
    int    n_errors = 0;
    string phase    = "init";

    // Model of the car: mode uses the external status codes, elapsed counts cycles spent in the segment.
    int m_mode, m_floor, m_elapsed;
    bit m_dir, m_arrive;

    elevator_scheduler #(.TRAVEL_CYCLES(TRAVEL), .DOOR_CYCLES(DOOR)) dut (
        .clk(clk), .rst(rst),
        .upcall(upcall), .downcall(downcall), .floor_btn(floor_btn),
        .floor(floor), .status(status), .dir(dir), .arrive(arrive), .door_open(door_open)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s/%s observed=%0d expected=%0d at %0t", phase, tag, obs, exp, $time);
        end
    endtask

    function automatic bit pend_above(input int f);
        logic [7:0] r;
        r = upcall | downcall | floor_btn;
        for (int i = f + 1; i < 8; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_below(input int f);
        logic [7:0] r;
        r = upcall | downcall | floor_btn;
        for (int i = 0; i < f; i++) if (r[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit pend_here(input int f);
        logic [7:0] r;
        r = upcall | downcall | floor_btn;
        return r[f];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_floor = 0; m_elapsed = 0; m_dir = 1'b1; m_arrive = 1'b0;
    endtask

    task automatic model_go(input int mode);
        m_mode    = mode;
        m_elapsed = 0;
        if (mode == 1) m_dir = 1'b1;
        if (mode == 2) m_dir = 1'b0;
    endtask

    task automatic model_step();
        bit ab, be, stop;
        ab = pend_above(m_floor);
        be = pend_below(m_floor);
        m_arrive = 1'b0;
        case (m_mode)
            0: begin
                if (pend_here(m_floor))  model_go(7);
                else if (ab && be && !m_dir) model_go(2);
                else if (ab)             model_go(1);
                else if (be)             model_go(2);
            end
            1, 2: begin
                m_elapsed++;
                if (m_elapsed == TRAVEL) begin
                    m_arrive = 1'b1;
                    if (m_mode == 1) begin
                        m_floor++;
                        stop = floor_btn[m_floor] || upcall[m_floor] ||
                               (downcall[m_floor] && !pend_above(m_floor));
                        if (stop) model_go(7);
                        else if (pend_above(m_floor)) m_elapsed = 0;
                        else model_go(0);
                    end else begin
                        m_floor--;
                        stop = floor_btn[m_floor] || downcall[m_floor] ||
                               (upcall[m_floor] && !pend_below(m_floor));
                        if (stop) model_go(7);
                        else if (pend_below(m_floor)) m_elapsed = 0;
                        else model_go(0);
                    end
                end
            end
            default: begin
                m_elapsed++;
                if (m_elapsed == DOOR) begin
                    if (m_dir && ab) model_go(1);
                    else if (be)     model_go(2);
                    else if (ab)     model_go(1);
                    else             model_go(0);
                end
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("floor",  32'(floor),     32'(m_floor));
        check_eq("status", 32'(status),    32'(m_mode));
        check_eq("dir",    32'(dir),       32'(m_dir));
        check_eq("arrive", 32'(arrive),    32'(m_arrive));
        check_eq("door",   32'(door_open), 32'(m_mode == 7));
    endtask

    // One clock: advance the model, compare on the falling edge, then let the buffer drop served calls.
    task automatic tick();
        @(posedge clk);
        if (!rst) model_reset();
        else      model_step();
        @(negedge clk);
        compare_all();
        if (m_mode == 7) begin
            upcall[m_floor]    = 1'b0;
            downcall[m_floor]  = 1'b0;
            floor_btn[m_floor] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        upcall = '0; downcall = '0; floor_btn = '0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        compare_all();
    endtask

    // Runs n cycles and records the floor and direction at the start of every door stop.
    task automatic run_collect_stops(input int n, output int stop_floor[$], output int stop_dir[$]);
        logic [3:0] prev;
        stop_floor = {};
        stop_dir   = {};
        prev = status;
        for (int i = 0; i < n; i++) begin
            tick();
            if (status == 4'd7 && prev != 4'd7) begin
                stop_floor.push_back(int'(floor));
                stop_dir.push_back(int'(dir));
            end
            prev = status;
        end
    endtask

    initial begin
        int sf[$];
        int sd[$];
        bit found;

        // Reset with arbitrary inputs, observed before any clock edge.
        phase = "reset";
        upcall = 8'($urandom); downcall = 8'($urandom); floor_btn = 8'($urandom);
        #1 rst = 1'b0;
        #1;
        check_eq("floor",  32'(floor),     0);
        check_eq("status", 32'(status),    0);
        check_eq("dir",    32'(dir),       1);
        check_eq("arrive", 32'(arrive),    0);
        check_eq("door",   32'(door_open), 0);
        do_reset();

        // Cab request to floor 3: one floor per TRAVEL cycles, then a DOOR-cycle stop.
        phase = "cab3";
        floor_btn = 8'h08;
        tick();
        check_eq("status_start", 32'(status), 1);
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 4)  begin check_eq("f1", 32'(floor), 1); check_eq("arr1", 32'(arrive), 1); end
            if (i == 5)  check_eq("arr1_end", 32'(arrive), 0);
            if (i == 8)  begin check_eq("f2", 32'(floor), 2); check_eq("arr2", 32'(arrive), 1); end
            if (i == 12) begin check_eq("f3", 32'(floor), 3); check_eq("st3", 32'(status), 7); end
            if (i == 14) check_eq("door_last", 32'(door_open), 1);
            if (i == 15) check_eq("st_idle", 32'(status), 0);
        end

        // Call at the current floor opens the door without moving.
        phase = "here";
        do_reset();
        upcall = 8'h01;
        tick();
        check_eq("st", 32'(status), 7);
        check_eq("door", 32'(door_open), 1);
        tick(); tick();
        check_eq("door3", 32'(door_open), 1);
        check_eq("floor", 32'(floor), 0);
        tick();
        check_eq("closed", 32'(status), 0);

        // Down-call at 2 is skipped on the way up to 5, then served going down.
        phase = "sweep";
        do_reset();
        floor_btn = 8'h20; downcall = 8'h04;
        run_collect_stops(60, sf, sd);
        check_eq("nstops", 32'(sf.size()), 2);
        if (sf.size() >= 2) begin
            check_eq("stop0", 32'(sf[0]), 5);
            check_eq("stop1", 32'(sf[1]), 2);
            check_eq("dir1",  32'(sd[1]), 0);
        end

        // Lone down-call above the car is served while still travelling up.
        phase = "topdown";
        do_reset();
        downcall = 8'h10;
        run_collect_stops(40, sf, sd);
        check_eq("nstops", 32'(sf.size()), 1);
        if (sf.size() >= 1) begin
            check_eq("stop0", 32'(sf[0]), 4);
            check_eq("dir0",  32'(sd[0]), 1);
        end

        // Asynchronous reset in the middle of an upward move.
        phase = "async";
        do_reset();
        floor_btn = 8'h80;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            if (floor == 3'd2 && status == 4'd1) found = 1'b1;
        end
        check_eq("reach2", 32'(found), 1);
        #2 rst = 1'b0;
        #1;
        check_eq("floor",  32'(floor),     0);
        check_eq("status", 32'(status),    0);
        check_eq("dir",    32'(dir),       1);
        check_eq("arrive", 32'(arrive),    0);
        model_reset();
        upcall = '0; downcall = '0; floor_btn = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_eq("stay_idle", 32'(status), 0);
        check_eq("stay_f0",   32'(floor),  0);

        // Random call traffic with periodic resets.
        phase = "random";
        for (int blk = 0; blk < 3; blk++) begin
            do_reset();
            for (int i = 0; i < 1500; i++) begin
                tick();
                if ($urandom_range(0, 5) == 0) begin
                    case ($urandom_range(0, 2))
                        0:       upcall[$urandom_range(0, 7)]    = 1'b1;
                        1:       downcall[$urandom_range(0, 7)]  = 1'b1;
                        default: floor_btn[$urandom_range(0, 7)] = 1'b1;
                    endcase
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/elevator_scheduler.md
ELEVATOR_SCHEDULER -- requirements
Module: elevator_scheduler

Interface
REQ-001 Parameter TRAVEL_CYCLES, default 100: clock cycles per one-floor move (range 1..65535).
REQ-002 Parameter DOOR_CYCLES, default 200: clock cycles the door stays open per stop (range 1..65535).
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 upcall  input  8  pending hall up-calls, bit i = floor i, from the status buffer.
REQ-006 downcall  input  8  pending hall down-calls, bit i = floor i.
REQ-007 floor_btn  input  8  pending in-cab floor requests, bit i = floor i.
REQ-008 floor  output  3  current car floor, 0..7, registered.
REQ-009 status  output  4  car state code: 0 IDLE, 1 MOVE_UP, 2 MOVE_DOWN, 7 DOOR_OPEN; registered.
REQ-010 dir  output  1  current/last travel direction, 1 up, 0 down.
REQ-011 arrive  output  1  one-cycle pulse on each floor change.
REQ-012 door_open  output  1  high exactly while status = 7.

Function
REQ-013 The block SHALL implement four states IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN, with status driven by the state code of REQ-009.
REQ-014 Definitions: req = upcall|downcall|floor_btn; above = any req bit > floor; below = any req bit < floor; here = req[floor].
REQ-015 IDLE: here -> DOOR_OPEN; else above and below with dir=0 -> MOVE_DOWN; else above -> MOVE_UP, dir=1; else below -> MOVE_DOWN, dir=0; else stay; transition takes effect on the next edge.
REQ-016 On entry to MOVE_UP/MOVE_DOWN a 16-bit travel counter SHALL load TRAVEL_CYCLES-1 and decrement each cycle.
REQ-017 At the edge where the travel counter is 0, floor SHALL become nf = floor+1 (up) or floor-1 (down) and arrive SHALL pulse for the following cycle.
REQ-018 Stop test at nf moving up: floor_btn[nf] | upcall[nf] | (downcall[nf] & no req above nf); moving down symmetric with downcall/upcall swapped.
REQ-019 At that same edge: stop -> DOOR_OPEN; else requests beyond nf in travel direction -> remain moving, counter reloaded; else -> IDLE.
REQ-020 floor SHALL never wrap: MOVE_UP is never entered or continued at floor 7, MOVE_DOWN never at floor 0.
REQ-021 On entry to DOOR_OPEN a door counter SHALL load DOOR_CYCLES-1; status=7 for exactly DOOR_CYCLES cycles (external buffer clears requests at floor while status=7).
REQ-022 At door counter 0: dir=1 and above -> MOVE_UP; else below -> MOVE_DOWN, dir=0; else above -> MOVE_UP, dir=1; else IDLE.
REQ-023 Request bits toggling during travel SHALL be honoured only at the next floor-arrival or door-close decision; no mid-floor reversal.
REQ-024 dir SHALL change only on entry to MOVE_UP (1) or MOVE_DOWN (0).

Reset
REQ-025 rst low SHALL immediately, without a clock edge, force state IDLE, floor=0, status=0, dir=1, arrive=0, door_open=0, both counters 0.
REQ-026 Reset asserted mid-move or mid-door SHALL abandon the operation; after release the block resumes from IDLE at floor 0.

Verification (TRAVEL_CYCLES=4, DOOR_CYCLES=3)
REQ-027 Reset: rst=0 with any inputs -> floor=0, status=0, dir=1, arrive=0 before the next clk edge.
REQ-028 IDLE at floor 0, floor_btn=8'h08 -> status=1 next cycle; floor 1,2,3 at +4,+8,+12 cycles with arrive pulses; then status=7 for 3 cycles; bench clears bit 3 -> status=0.
REQ-029 IDLE at floor 0, upcall=8'h01 -> status=7 next cycle, door_open=1 for 3 cycles, floor unchanged.
REQ-030 From floor 0, floor_btn=8'h20 and downcall=8'h04 -> passes floor 2 without stopping, stops at 5 (status 7), then status=2, dir=0, stops at floor 2.
REQ-031 From floor 0, downcall=8'h10 only -> car moves up and stops at floor 4 (no request above), dir=1 during stop.
REQ-032 rst pulsed low while status=1 at floor 2 -> floor=0, status=0 asynchronously; with inputs 0 after release, stays IDLE.
